// File: rtl/seq_comparator_pkg.sv
// Shared types, result encoding and sizing helper for the sequential magnitude comparator.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // One-hot result encoding: bit 0 = equal, bit 1 = less, bit 2 = greater.
  localparam int unsigned RES_W = 3;
  localparam logic [RES_W-1:0] RES_EQ = 3'b001;
  localparam logic [RES_W-1:0] RES_LT = 3'b010;
  localparam logic [RES_W-1:0] RES_GT = 3'b100;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_comparator_if.sv
// Operand/result handshake bundle for seq_comparator; master drives operands, slave is the comparator.
interface seq_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             less_than;
  logic             greater_than;

  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, equal, less_than, greater_than
  );

  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, equal, less_than, greater_than
  );
endinterface

// File: rtl/seq_comparator_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice of both operands.
module chunk_cmp #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             differ_c,
  output logic             a_gt_c
);

  assign differ_c = (a_i != b_i);
  assign a_gt_c   = (a_i > b_i);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock, MSB first, valid/ready on both sides.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish on the first differing chunk instead of a fixed latency.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic           clk,
  input  logic           rst,
  seq_comparator_if.slave bus
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned CNT_W      = cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_comparator: WIDTH must be >= 2 and an exact multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             differ_c;
  logic             a_gt_c;
  logic             undecided_c;

  chunk_cmp #(
    .CHUNK(CHUNK)
  ) u_chunk_cmp (
    .a_i     (a_q[WIDTH-1 -: CHUNK]),
    .b_i     (b_q[WIDTH-1 -: CHUNK]),
    .differ_c(differ_c),
    .a_gt_c  (a_gt_c)
  );

  assign undecided_c = (res_q == '0);

  // Next-state: flipping both MSBs turns a two's-complement compare into an unsigned one.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d     = bus.A ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
          b_d     = bus.B ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
          cnt_d   = '0;
          res_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        a_d   = a_q << CHUNK;
        b_d   = b_q << CHUNK;
        cnt_d = cnt_q + CNT_W'(1);
        if (undecided_c && differ_c) begin
          res_d = a_gt_c ? RES_GT : RES_LT;
        end
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (undecided_c && !differ_c) begin
            res_d = RES_EQ;
          end
        end
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
        if (undecided_c && differ_c) begin
          state_d = DONE;
        end
`else
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Flags keep their value after the output handshake until the next capture clears them.
  assign bus.in_ready     = (state_q == IDLE) && !rst;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.equal        = |(res_q & RES_EQ);
  assign bus.less_than    = |(res_q & RES_LT);
  assign bus.greater_than = |(res_q & RES_GT);

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard testbench for seq_comparator (WIDTH=8, CHUNK=2); honours SEQ_COMPARATOR_EARLY_EXIT_EN.
module tb_seq_comparator;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned CHUNK      = 2;
  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  res;
    int unsigned lat;
    int unsigned hs_edge;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  txn_t        sb_q[$];
  bit          b2b_chk = 1'b0;

  seq_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_comparator #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Flags as {gt, lt, eq}.
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sm);
    logic signed [WIDTH:0] sa;
    logic signed [WIDTH:0] sb;
    sa = sm ? {a[WIDTH-1], a} : {1'b0, a};
    sb = sm ? {b[WIDTH-1], b} : {1'b0, b};
    if (sa < sb) return 3'b010;
    if (sa > sb) return 3'b100;
    return 3'b001;
  endfunction

  function automatic int unsigned model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    int unsigned      first;
    x     = a ^ b;
    first = NUM_CHUNKS;
    for (int k = int'(NUM_CHUNKS) - 1; k >= 0; k--) begin
      if (x[WIDTH-1-k*CHUNK -: CHUNK] != '0) first = 32'(k);
    end
    return (EARLY && (first < NUM_CHUNKS)) ? first + 1 : NUM_CHUNKS;
  endfunction

  // Monitor: samples on the falling edge, pushes on input handshake, checks on output.
  logic       ov_prev = 1'b0;
  logic       or_prev = 1'b0;
  logic [2:0] flags_prev = 3'b000;
  int unsigned last_rise = 0;
  bit          have_rise = 1'b0;
  always @(negedge clk) begin : mon
    logic [2:0] flags;
    txn_t       t;
    flags = {bus.greater_than, bus.less_than, bus.equal};
    if (!b2b_chk) have_rise = 1'b0;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (ov_prev && !or_prev) begin
        check_eq("hold_valid", 32'(bus.out_valid), 1);
        check_eq("hold_flags", 32'(flags), 32'(flags_prev));
      end
      if (bus.out_valid && !ov_prev) begin
        if (sb_q.size() == 0) begin
          check_eq("out_valid_without_txn", 32'(sb_q.size()), 1);
        end else begin
          check_eq("latency", cyc - sb_q[0].hs_edge, sb_q[0].lat);
          if (b2b_chk && have_rise) check_eq("b2b_spacing", cyc - last_rise, sb_q[0].lat + 2);
          last_rise = cyc;
          have_rise = 1'b1;
        end
      end
      if (bus.out_valid && bus.out_ready && (sb_q.size() != 0)) begin
        check_eq("result", 32'(flags), 32'(sb_q[0].res));
        void'(sb_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        t.res     = model_res(bus.A, bus.B, bus.signed_mode);
        t.lat     = model_lat(bus.A, bus.B);
        t.hs_edge = cyc + 1;
        sb_q.push_back(t);
      end
    end
    ov_prev    = bus.out_valid;
    or_prev    = bus.out_ready;
    flags_prev = flags;
  end

  // All driver tasks start and end just after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                      input bit hold);
    logic acc;
    acc             = 1'b0;
    bus.A           = a;
    bus.B           = b;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) break;
    end
    if (!hold) bus.in_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 32'(acc), 1);
  endtask

  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
      step();
      if (seen) break;
    end
    if (!seen) check_eq("result_timeout", 32'(seen), 1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    wait_valid();
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.A           = '0;
    bus.B           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_flags", 32'({bus.greater_than, bus.less_than, bus.equal}), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 1);
    step();

    // Directed operand patterns
    send(8'h00, 8'h00, 1'b0, 1'b0); drain();
    send(8'h80, 8'h40, 1'b0, 1'b0); drain();
    send(8'h80, 8'h40, 1'b1, 1'b0); drain();
    send(8'h93, 8'h92, 1'b0, 1'b0); drain();
    send(8'hFF, 8'h01, 1'b1, 1'b0); drain();
    send(8'h80, 8'h7F, 1'b1, 1'b0); drain();
    send(8'h80, 8'h7F, 1'b0, 1'b0); drain();

    // Backpressure with a new operand pair waiting
    bus.out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 1'b0);
    wait_valid();
    bus.A           = 8'h55;
    bus.B           = 8'h33;
    bus.signed_mode = 1'b0;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(bus.in_ready), 0);
      check_eq("bp_out_valid", 32'(bus.out_valid), 1);
      check_eq("bp_flags", 32'({bus.greater_than, bus.less_than, bus.equal}), 32'(3'b010));
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_in_ready", 32'(bus.in_ready), 0);
    step();
    @(negedge clk);
    check_eq("bp_idle_in_ready", 32'(bus.in_ready), 1);
    check_eq("bp_idle_out_valid", 32'(bus.out_valid), 0);
    check_eq("bp_flags_kept", 32'({bus.greater_than, bus.less_than, bus.equal}), 32'(3'b010));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_captured_in_ready", 32'(bus.in_ready), 0);
    check_eq("bp_flags_cleared", 32'({bus.greater_than, bus.less_than, bus.equal}), 0);
    step();
    drain();

    // Reset one cycle into COMPARE aborts the transaction
    send(8'h10, 8'h20, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ready", 32'(bus.in_ready), 0);
    step();
    @(negedge clk);
    check_eq("abort_out_valid", 32'(bus.out_valid), 0);
    check_eq("abort_flags", 32'({bus.greater_than, bus.less_than, bus.equal}), 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    check_eq("abort_post_in_ready", 32'(bus.in_ready), 1);
    step();
    repeat (8) step();

    // Back-to-back random traffic with in_valid and out_ready held high
    b2b_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rs;
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 1'b1);
    end
    bus.in_valid = 1'b0;
    repeat (12) step();
    b2b_chk = 1'b0;
    check_eq("sb_empty", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time %0t, expected $finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
